sram_stream_adapter: RTL and testbench
======================================

Name: sram_stream_adapter

Overview:
- Valid/ready front-end that sits directly upstream of the generic single-port SRAM macro and drives its req/we/addr/wdata/be port.
- Tracks read requests in flight through the macro's fixed read latency.
- Captures returned read data into a response FIFO, so consumers can apply backpressure without losing data.
- Read issue is credit-limited, so the FIFO can never overflow.

Parameters:
- NumWords, 1024, words in the attached SRAM; AddrWidth = (NumWords>1) ? clog2(NumWords) : 1
- DataWidth, 32, data width
- ByteWidth, 8, byte width; BeWidth = ceil(DataWidth/ByteWidth)
- Latency, 1, read latency of the attached SRAM in cycles; 0..8 allowed
- BufDepth, 4, response FIFO depth and maximum outstanding reads; >=1

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_we_i  in  1  1 = write, 0 = read
- req_addr_i  in  AddrWidth  word address
- req_wdata_i  in  DataWidth  write data
- req_be_i  in  BeWidth  byte enables
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid&ready
- rsp_rdata_o  out  DataWidth  response data
- sram_req_o  out  1  SRAM request
- sram_we_o  out  1  SRAM write enable
- sram_addr_o  out  AddrWidth  SRAM address
- sram_wdata_o  out  DataWidth  SRAM write data
- sram_be_o  out  BeWidth  SRAM byte enables
- sram_rdata_i  in  DataWidth  SRAM read data, valid Latency cycles after a read request

Behaviour:
- **Pass-through:** sram_req_o = req_valid_i & req_ready_o. sram_we_o, sram_addr_o, sram_wdata_o and sram_be_o are combinational copies of the req_* inputs. No request register.
- **Credits:** credits = BufDepth - (fifo_count + inflight).
  - Both counters are registered; width clog2(BufDepth+1).
- **Ready:** req_ready_o = req_we_i | (credits != 0).
  - A read needs one credit; a write needs none.
  - rsp_ready_i has no combinational path to req_ready_o. A pop frees its credit from the next cycle.
- **Tracking:** Latency-stage shift register of read-valid bits. Stage 0 loads (accepted & !we); the bit shifts every cycle.
  - inflight counts ones in the pipe, or is kept as a counter: +1 on read accept, -1 on pipe exit.
  - Latency=0: read data is captured in the same cycle as the request; the pipe is empty.
- **Capture:** when the pipe-exit bit is set, push sram_rdata_i into the FIFO at that edge.
  - A read accepted in cycle 0 has rsp_valid_o=1 in cycle Latency+1, provided the FIFO was empty.
- **FIFO:** BufDepth entries, circular read/write pointers, not fall-through.
  - rsp_valid_o = (fifo_count != 0); rsp_rdata_o = entry at the read pointer.
  - Push and pop in the same cycle leave the count unchanged; pointers wrap at BufDepth.
  - Push while full cannot occur by construction (assertion).
- **Ordering:** responses return in read-issue order. The SRAM resolves write/read ordering, so a write followed by a read to the same address returns the new data.
- **Reset values:** req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, FIFO storage=0, pointers=0, counters=0, pipe=0.
  - Reset mid-operation discards in-flight reads and buffered responses. Data returning from the SRAM after reset deassertion is ignored because the pipe is cleared.
- **Out-of-range address:** passed through unchanged; a simulation assertion warns when addr >= NumWords on an accepted request.
- **Stall rule:** the request side may change req_* while req_ready_o=0. The response side must hold rsp_valid_o/rsp_rdata_o stable until rsp_ready_i.

Optional Feature:
- Macro: SRAM_STREAM_ADAPTER_WRITE_RSP_EN.
- **Defined:** every accepted write also consumes a credit and pushes a response with rsp_rdata_o = 0. The response travels through the same Latency pipe, so read and write responses stay in issue order. req_ready_o = (credits != 0) for all requests.
- **Undefined:** writes produce no response and need no credit, as above.

Test Plan:
- **Single read:** Latency=1, BufDepth=4. Write 0xDEADBEEF to addr 5 (be=0xF), then read addr 5 -> rsp_valid_o=1 two cycles after the read handshake, rsp_rdata_o=0xDEADBEEF.
- **Backpressure:** Latency=2, rsp_ready_i=0. Issue 6 back-to-back reads of addr 0..5 (preloaded data = addr) -> exactly 4 accepted, req_ready_o=0 for reads afterwards. Then rsp_ready_i=1 -> responses 0,1,2,3, then reads 4,5 proceed and return 4,5. No drop, no duplicate.
- **Write bypasses credit:** full FIFO, no feature macro. Write 0x12345678 to addr 9 -> accepted immediately. After draining, read addr 9 -> 0x12345678.
- **Byte enables:** word 3 = 0xFFFFFFFF; write 0x00000000 with be=0x5; read -> 0xFF00FF00.
- **Reset mid-flight:** Latency=3. Assert rst_i one cycle after 2 reads are accepted -> rsp_valid_o=0, req_ready_o=1 throughout. No response appears after release.
- **Latency=0, simultaneous push and pop:** rsp_ready_i=1 with a read every cycle over addr 0..7 -> continuous responses 0..7, one per cycle from cycle 1. fifo_count never exceeds 1.

Source files
------------

// File: rtl/sram_stream_adapter.sv
// sram_stream_adapter
//   Valid/ready front-end for a single-port SRAM macro with a fixed read
//   latency. Requests pass straight through to the macro. Read data is
//   tracked through a valid-bit pipe that is as long as the macro latency,
//   then captured into a small response FIFO. Reads are credit-limited so
//   the FIFO never overflows; a pop returns its credit from the next cycle.
//
//   Optional feature macro: SRAM_STREAM_ADAPTER_WRITE_RSP_EN
//     defined   - writes also consume a credit and return a zero response,
//                 in issue order with the reads.
//     undefined - writes produce no response and need no credit.
module sram_stream_adapter #(
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned Latency   = 1,
  parameter int unsigned BufDepth  = 4,
  localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
  localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  input  logic [BeWidth-1:0]   req_be_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [BeWidth-1:0]   sram_be_o,
  input  logic [DataWidth-1:0] sram_rdata_i
);

  localparam int unsigned CntWidth = $clog2(BufDepth + 1);
  localparam int unsigned PtrWidth = (BufDepth > 1) ? $clog2(BufDepth) : 1;
  localparam logic [CntWidth:0] DepthCnt = BufDepth[CntWidth:0];

  // Handshake / credit signals
  logic                 accept;
  logic                 load;       // request that will produce a response
  logic                 exit_bit;   // response data is on sram_rdata_i this cycle
  logic                 credit_avail;
  logic [CntWidth:0]    occupancy;  // buffered + in-flight responses

  // Response FIFO state
  logic [DataWidth-1:0] fifo_mem_q [BufDepth];
  logic [DataWidth-1:0] fifo_mem_d [BufDepth];
  logic [PtrWidth-1:0]  wptr_q, wptr_d;
  logic [PtrWidth-1:0]  rptr_q, rptr_d;
  logic [CntWidth-1:0]  fifo_count_q, fifo_count_d;
  logic [CntWidth-1:0]  inflight_q, inflight_d;
  logic                 push, pop;
  logic [DataWidth-1:0] push_data;

  // ---------------------------------------------------------------------------
  // Credits and request acceptance
  // ---------------------------------------------------------------------------
  // Both terms are registered, so rsp_ready_i never reaches req_ready_o
  // combinationally; a pop shows up as a free credit one cycle later.
  assign occupancy    = {1'b0, fifo_count_q} + {1'b0, inflight_q};
  assign credit_avail = occupancy < DepthCnt;

`ifdef SRAM_STREAM_ADAPTER_WRITE_RSP_EN
  assign req_ready_o = credit_avail;
  assign accept      = req_valid_i & req_ready_o;
  assign load        = accept;
`else
  assign req_ready_o = req_we_i | credit_avail;
  assign accept      = req_valid_i & req_ready_o;
  assign load        = accept & ~req_we_i;
`endif

  // Straight pass-through to the macro; no request register in the path.
  assign sram_req_o   = accept;
  assign sram_we_o    = req_we_i;
  assign sram_addr_o  = req_addr_i;
  assign sram_wdata_o = req_wdata_i;
  assign sram_be_o    = req_be_i;

  // ---------------------------------------------------------------------------
  // Read tracking pipe
  // ---------------------------------------------------------------------------
`ifdef SRAM_STREAM_ADAPTER_WRITE_RSP_EN
  logic exit_we;  // response leaving the pipe belongs to a write
  assign push_data = exit_we ? '0 : sram_rdata_i;
`else
  assign push_data = sram_rdata_i;
`endif

  if (Latency == 0) begin : g_lat0
    // Zero-latency macro: data is on sram_rdata_i in the request cycle.
    assign exit_bit = load;
`ifdef SRAM_STREAM_ADAPTER_WRITE_RSP_EN
    assign exit_we  = req_we_i;
`endif
  end else begin : g_pipe
    logic [Latency-1:0] vld_pipe_q, vld_pipe_d;

    // Shift the response-valid bits one stage per cycle.
    always_comb begin
      vld_pipe_d    = '0;
      vld_pipe_d[0] = load;
      for (int i = 1; i < Latency; i++) vld_pipe_d[i] = vld_pipe_q[i-1];
    end

    // Pipe register; reset discards everything in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) vld_pipe_q <= '0;
      else       vld_pipe_q <= vld_pipe_d;
    end

    assign exit_bit = vld_pipe_q[Latency-1];

`ifdef SRAM_STREAM_ADAPTER_WRITE_RSP_EN
    logic [Latency-1:0] we_pipe_q, we_pipe_d;

    // Carry the write flag alongside the valid bit.
    always_comb begin
      we_pipe_d    = '0;
      we_pipe_d[0] = load & req_we_i;
      for (int i = 1; i < Latency; i++) we_pipe_d[i] = we_pipe_q[i-1];
    end

    // Write-flag pipe register.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) we_pipe_q <= '0;
      else       we_pipe_q <= we_pipe_d;
    end

    assign exit_we = we_pipe_q[Latency-1];
`endif
  end

  // In-flight counter: +1 on load, -1 as a bit leaves the pipe.
  always_comb begin
    inflight_d = inflight_q + CntWidth'(load) - CntWidth'(exit_bit);
  end

  // In-flight counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) inflight_q <= '0;
    else       inflight_q <= inflight_d;
  end

  // ---------------------------------------------------------------------------
  // Response FIFO
  // ---------------------------------------------------------------------------
  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    if (p == PtrWidth'(BufDepth - 1)) return '0;
    return p + PtrWidth'(1);
  endfunction

  assign push        = exit_bit;
  assign rsp_valid_o = (fifo_count_q != '0);
  assign pop         = rsp_valid_o & rsp_ready_i;
  assign rsp_rdata_o = fifo_mem_q[rptr_q];

  // Next-state for storage, pointers and count.
  always_comb begin
    fifo_mem_d   = fifo_mem_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    fifo_count_d = fifo_count_q;
    if (push) begin
      fifo_mem_d[wptr_q] = push_data;
      wptr_d             = ptr_inc(wptr_q);
    end
    if (pop) rptr_d = ptr_inc(rptr_q);
    case ({push, pop})
      2'b10:   fifo_count_d = fifo_count_q + CntWidth'(1);
      2'b01:   fifo_count_d = fifo_count_q - CntWidth'(1);
      default: fifo_count_d = fifo_count_q;
    endcase
  end

  // FIFO registers; storage is cleared so rsp_rdata_o reads zero out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < BufDepth; i++) fifo_mem_q[i] <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      fifo_count_q <= '0;
    end else begin
      fifo_mem_q   <= fifo_mem_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      fifo_count_q <= fifo_count_d;
    end
  end

`ifndef SYNTHESIS
  // Sanity checks: credit accounting must make a full-FIFO push impossible,
  // and out-of-range addresses are flagged but still passed through.
  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(push && fifo_count_q == CntWidth'(BufDepth)))
        else $error("sram_stream_adapter: push into full response FIFO");
      assert (!(accept && 32'(req_addr_i) >= NumWords))
        else $warning("sram_stream_adapter: address %0d beyond NumWords", req_addr_i);
    end
  end
`endif

endmodule

// File: tb/tb_sram_stream_adapter.sv
// Directed bench for sram_stream_adapter. Four DUT instances with read
// latency 0..3 each drive their own behavioural SRAM (preloaded word i = i
// while reset is high). Instance k is selected by index in every task.
module tb_sram_stream_adapter;
  localparam int NI = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NI-1:0]       req_valid, req_we, rsp_ready;
  logic [NI-1:0][3:0]  req_addr, req_be;
  logic [NI-1:0][31:0] req_wdata;
  wire  [NI-1:0]       req_ready, rsp_valid;
  wire  [NI-1:0][31:0] rsp_rdata;

  int tests = 0;
  int fails = 0;
  logic [31:0] got[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_inst
    logic        sreq, swe;
    logic [3:0]  saddr, sbe;
    logic [31:0] swdata, srdata;
    logic [31:0] mem [16];

    sram_stream_adapter #(
      .NumWords(16), .DataWidth(32), .ByteWidth(8), .Latency(g), .BufDepth(4)
    ) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid[g]), .req_ready_o(req_ready[g]),
      .req_we_i(req_we[g]), .req_addr_i(req_addr[g]),
      .req_wdata_i(req_wdata[g]), .req_be_i(req_be[g]),
      .rsp_valid_o(rsp_valid[g]), .rsp_ready_i(rsp_ready[g]),
      .rsp_rdata_o(rsp_rdata[g]),
      .sram_req_o(sreq), .sram_we_o(swe), .sram_addr_o(saddr),
      .sram_wdata_o(swdata), .sram_be_o(sbe), .sram_rdata_i(srdata)
    );

    // SRAM model: preload pattern during reset, byte-masked writes otherwise.
    always @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < 16; i++) mem[i] <= i;
      end else if (sreq && swe) begin
        for (int b = 0; b < 4; b++)
          if (sbe[b]) mem[saddr][8*b +: 8] <= swdata[8*b +: 8];
      end
    end

    if (g == 0) begin : g_comb
      assign srdata = mem[saddr];
    end else begin : g_seq
      logic [31:0] dly [g];
      always @(posedge clk) begin
        if (sreq && !swe) dly[0] <= mem[saddr];
        for (int i = 1; i < g; i++) dly[i] <= dly[i-1];
      end
      assign srdata = dly[g-1];
    end
  end

  // Hold a request until handshake; returns cycles spent waiting.
  task automatic do_req(input int k, input logic we, input logic [3:0] a,
                        input logic [31:0] wd, input logic [3:0] be, output int waits);
    logic done;
    req_valid[k] = 1'b1; req_we[k] = we; req_addr[k] = a;
    req_wdata[k] = wd;   req_be[k] = be;
    waits = 0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      done = req_ready[k];
      @(posedge clk); #1;
      if (!done) begin
        waits++;
        if (waits > 50) begin
          tests++; fails++;
          $display("FAIL req_timeout inst=%0d: no handshake in 50 cycles", k);
          done = 1'b1;
        end
      end
    end
    req_valid[k] = 1'b0;
  endtask

  // Pop up to n responses into got (bounded wait).
  task automatic collect(input int k, input int n);
    got.delete();
    rsp_ready[k] = 1'b1;
    for (int c = 0; c < 20 && got.size() < n; c++) begin
      @(negedge clk);
      if (rsp_valid[k]) got.push_back(rsp_rdata[k]);
      @(posedge clk); #1;
    end
    rsp_ready[k] = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      tests++; if (req_ready[k] !== 1'b1) begin fails++; $display("FAIL reset_ready inst=%0d: got %b want 1", k, req_ready[k]); end
      tests++; if (rsp_valid[k] !== 1'b0) begin fails++; $display("FAIL reset_valid inst=%0d: got %b want 0", k, rsp_valid[k]); end
      tests++; if (rsp_rdata[k] !== 32'h0) begin fails++; $display("FAIL reset_rdata inst=%0d: got %h want 0", k, rsp_rdata[k]); end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_read();
    int w;
    do_req(1, 1'b1, 4'd5, 32'hDEADBEEF, 4'hF, w);
    do_req(1, 1'b0, 4'd5, 32'h0, 4'hF, w);
    tests++; if (w !== 0) begin fails++; $display("FAIL single_accept: waited %0d want 0", w); end
    @(negedge clk);
    tests++; if (rsp_valid[1] !== 1'b0) begin fails++; $display("FAIL single_early: valid %b want 0", rsp_valid[1]); end
    @(posedge clk); #1;
    @(negedge clk);
    tests++; if (rsp_valid[1] !== 1'b1) begin fails++; $display("FAIL single_valid: valid %b want 1", rsp_valid[1]); end
    tests++; if (rsp_rdata[1] !== 32'hDEADBEEF) begin fails++; $display("FAIL single_data: got %h want deadbeef", rsp_rdata[1]); end
    @(posedge clk); #1;
    collect(1, 1);
    @(negedge clk);
    tests++; if (rsp_valid[1] !== 1'b0) begin fails++; $display("FAIL single_drained: valid %b want 0", rsp_valid[1]); end
    @(posedge clk); #1;
  endtask

  task automatic test_write_bypass();
    int w;
    for (int a = 0; a < 4; a++) begin
      do_req(1, 1'b0, 4'(a), 32'h0, 4'hF, w);
      tests++; if (w !== 0) begin fails++; $display("FAIL bypass_fill%0d: waited %0d want 0", a, w); end
    end
    repeat (2) @(posedge clk); #1;
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 4'd9;
    @(negedge clk);
    tests++; if (req_ready[1] !== 1'b0) begin fails++; $display("FAIL bypass_read_blocked: ready %b want 0", req_ready[1]); end
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    do_req(1, 1'b1, 4'd9, 32'h12345678, 4'hF, w);
    tests++; if (w !== 0) begin fails++; $display("FAIL bypass_write: waited %0d want 0", w); end
    collect(1, 4);
    tests++; if (got.size() != 4) begin fails++; $display("FAIL bypass_drain_count: got %0d want 4", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      tests++; if (got[i] !== 32'(i)) begin fails++; $display("FAIL bypass_drain%0d: got %h want %h", i, got[i], i); end
    end
    do_req(1, 1'b0, 4'd9, 32'h0, 4'hF, w);
    collect(1, 1);
    tests++; if (got.size() != 1 || got[0] !== 32'h12345678) begin fails++; $display("FAIL bypass_readback: size %0d want 1 of 12345678", got.size()); end
  endtask

  task automatic test_byte_enable();
    int w;
    do_req(1, 1'b1, 4'd3, 32'hFFFFFFFF, 4'hF, w);
    do_req(1, 1'b1, 4'd3, 32'h00000000, 4'h5, w);
    do_req(1, 1'b0, 4'd3, 32'h0, 4'hF, w);
    collect(1, 1);
    tests++; if (got.size() != 1) begin fails++; $display("FAIL be_count: got %0d want 1", got.size()); end
    else begin
      tests++; if (got[0] !== 32'hFF00FF00) begin fails++; $display("FAIL be_data: got %h want ff00ff00", got[0]); end
    end
  endtask

  task automatic test_backpressure();
    int w, next_a;
    logic acc;
    rsp_ready[2] = 1'b0;
    for (int a = 0; a < 4; a++) begin
      do_req(2, 1'b0, 4'(a), 32'h0, 4'hF, w);
      tests++; if (w !== 0) begin fails++; $display("FAIL bp_accept%0d: waited %0d want 0", a, w); end
    end
    req_valid[2] = 1'b1; req_we[2] = 1'b0; req_addr[2] = 4'd4;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      tests++; if (req_ready[2] !== 1'b0) begin fails++; $display("FAIL bp_blocked c%0d: ready %b want 0", c, req_ready[2]); end
      @(posedge clk); #1;
    end
    @(negedge clk);
    tests++; if (rsp_valid[2] !== 1'b1 || rsp_rdata[2] !== 32'h0) begin fails++; $display("FAIL bp_head: valid %b data %h want 1/0", rsp_valid[2], rsp_rdata[2]); end
    @(posedge clk); #1;
    got.delete();
    rsp_ready[2] = 1'b1;
    next_a = 4;
    for (int c = 0; c < 40 && got.size() < 6; c++) begin
      @(negedge clk);
      if (rsp_valid[2]) got.push_back(rsp_rdata[2]);
      acc = req_valid[2] & req_ready[2];
      @(posedge clk); #1;
      if (acc) begin
        next_a++;
        if (next_a == 6) req_valid[2] = 1'b0;
        else req_addr[2] = 4'(next_a);
      end
    end
    req_valid[2] = 1'b0;
    tests++; if (got.size() != 6) begin fails++; $display("FAIL bp_count: got %0d want 6", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      tests++; if (got[i] !== 32'(i)) begin fails++; $display("FAIL bp_order%0d: got %h want %h", i, got[i], i); end
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    tests++; if (rsp_valid[2] !== 1'b0) begin fails++; $display("FAIL bp_no_dup: valid %b want 0", rsp_valid[2]); end
    rsp_ready[2] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_lat0_stream();
    rsp_ready[0] = 1'b1;
    req_we[0] = 1'b0; req_be[0] = 4'hF;
    for (int c = 0; c < 10; c++) begin
      req_valid[0] = (c < 8);
      req_addr[0]  = 4'(c);
      @(negedge clk);
      if (c < 8) begin
        tests++; if (req_ready[0] !== 1'b1) begin fails++; $display("FAIL l0_ready c%0d: got %b want 1", c, req_ready[0]); end
      end
      if (c >= 1 && c <= 8) begin
        tests++; if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'(c - 1)) begin fails++; $display("FAIL l0_rsp c%0d: valid %b data %h want 1/%h", c, rsp_valid[0], rsp_rdata[0], c - 1); end
      end else begin
        tests++; if (rsp_valid[0] !== 1'b0) begin fails++; $display("FAIL l0_idle c%0d: valid %b want 0", c, rsp_valid[0]); end
      end
      @(posedge clk); #1;
    end
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b0;
  endtask

  task automatic test_reset_midflight();
    int w;
    rsp_ready[3] = 1'b0;
    do_req(3, 1'b0, 4'd1, 32'h0, 4'hF, w);
    do_req(3, 1'b0, 4'd2, 32'h0, 4'hF, w);
    @(negedge clk);
    tests++; if (rsp_valid[3] !== 1'b0 || req_ready[3] !== 1'b1) begin fails++; $display("FAIL rstmid_pre: valid %b ready %b want 0/1", rsp_valid[3], req_ready[3]); end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++; if (rsp_valid[3] !== 1'b0 || req_ready[3] !== 1'b1) begin fails++; $display("FAIL rstmid_hold c%0d: valid %b ready %b want 0/1", c, rsp_valid[3], req_ready[3]); end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      tests++; if (rsp_valid[3] !== 1'b0 || req_ready[3] !== 1'b1) begin fails++; $display("FAIL rstmid_after c%0d: valid %b ready %b want 0/1", c, rsp_valid[3], req_ready[3]); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    req_valid = '0; req_we = '0; req_addr = '0;
    req_wdata = '0; req_be = '0; rsp_ready = '0;
    test_reset();
    test_single_read();
    test_write_bypass();
    test_byte_enable();
    test_backpressure();
    test_lat0_stream();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
